// File: rtl/spi_slave_with_modes.sv
// spi_slave_with_modes: oversampled SPI slave for all four CPOL/CPHA modes, MSB-first frames
// Ports: clk, rst (async, active-high); mode {cpol,cpha} latched at cs fall;
//        sclk, cs (active low), mosi from the master; miso back to the master;
//        tx_data byte to send, tx_load strobes when it has been captured;
//        rx_data/rx_valid last received byte and its strobe; frame_err strobes when cs
//        rises on a partial frame; busy while a transaction is open.
module spi_slave_with_modes #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_load,
    output logic             frame_err,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic sclk_hist_q, sclk_hist_d, cs_hist_q, cs_hist_d;
    logic cpol_q, cpol_d, cpha_q, cpha_d, skip_q, skip_d, miso_q, miso_d;
    logic rx_pend_q, rx_pend_d, rx_valid_q, rx_valid_d, tx_load_q, tx_load_d, frame_err_q, frame_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d, rx_next, tx_pre;
    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise, lead, trail, sample, shift, wrap;
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign lead      = cpol_q ? sclk_fall : sclk_rise;
    assign trail     = cpol_q ? sclk_rise : sclk_fall;
    assign sample    = cpha_q ? trail : lead;
    assign shift     = cpha_q ? lead : trail;
    assign rx_next   = {rx_sh_q[WIDTH-2:0], mosi_s};
    assign wrap      = sample && (cnt_q == CW'(WIDTH - 1));
    // With CPHA=0 the MSB goes straight onto miso, so the shifter keeps only the remaining bits.
    assign tx_pre    = {tx_data[WIDTH-2:0], 1'b0};
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        skip_d      = skip_q;
        miso_d      = miso_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        rx_pend_d   = 1'b0;
        rx_valid_d  = rx_pend_q;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == IDLE) begin
            miso_d = 1'b0;
            if (cs_fall) begin
                state_d   = ACTIVE;
                cpol_d    = mode[1];
                cpha_d    = mode[0];
                skip_d    = 1'b0;
                cnt_d     = '0;
                rx_sh_d   = '0;
                tx_load_d = 1'b1;
                tx_sh_d   = mode[0] ? tx_data : tx_pre;
                miso_d    = ~mode[0] & tx_data[WIDTH-1];
            end
        end else if (cs_rise) begin
            state_d     = IDLE;
            miso_d      = 1'b0;
            frame_err_d = (cnt_q != '0);
            cnt_d       = '0;
            rx_sh_d     = '0;
        end else begin
            if (sample) begin
                rx_sh_d = rx_next;
                cnt_d   = wrap ? '0 : cnt_q + CW'(1);
            end
            // rx_valid trails the wrap by a cycle so it never coincides with tx_load.
            if (wrap) begin
                rx_data_d = rx_next;
                rx_pend_d = 1'b1;
                tx_load_d = 1'b1;
                tx_sh_d   = cpha_q ? tx_data : tx_pre;
                miso_d    = cpha_q ? miso_q : tx_data[WIDTH-1];
                skip_d    = ~cpha_q;
            end
            if (shift) begin
                skip_d  = 1'b0;
                miso_d  = skip_q ? miso_q : tx_sh_q[WIDTH-1];
                tx_sh_d = skip_q ? tx_sh_q : {tx_sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            skip_q      <= 1'b0;
            miso_q      <= 1'b0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            skip_q      <= skip_d;
            miso_q      <= miso_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_with_modes.sv
// tb_spi_slave_with_modes: table-driven and scoreboard bench for spi_slave_with_modes
module tb_spi_slave_with_modes;
    localparam int H = 6;
    logic clk = 1'b0;
    logic rst, sclk, cs, mosi, miso, rx_valid, tx_load, frame_err, busy;
    logic [1:0] mode;
    logic [7:0] tx_data, rx_data;
    int checks = 0, errors = 0;
    int rxv_cnt = 0, txl_cnt = 0, fe_cnt = 0;
    logic [7:0] sb[$];
    typedef struct {
        logic [1:0] m;
        logic [7:0] mosi_b;
        logic [7:0] tx_b;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vecs[5];

    spi_slave_with_modes #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .cs(cs), .mosi(mosi),
        .tx_data(tx_data), .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_load(tx_load), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            if (sb.size() == 0) chk("rx_valid_unexpected", 32'd1, 32'd0);
            else chk("rx_data_sb", {24'd0, rx_data}, {24'd0, sb.pop_front()});
        end
        if (tx_load) txl_cnt++;
        if (frame_err) fe_cnt++;
        if (rx_valid || tx_load || frame_err)
            chk("strobe_exclusive", 32'(rx_valid) + 32'(tx_load) + 32'(frame_err), 32'd1);
    end

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_low(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        wait_h();
        cs = 1'b0;
        wait_h();
    endtask

    task automatic cs_high();
        wait_h();
        cs = 1'b1;
        wait_h();
        wait_h();
    endtask

    task automatic xfer_bits(input logic [1:0] m, input logic [7:0] d, input int n, output logic [7:0] got);
        got = '0;
        for (int i = 7; i >= 8 - n; i--) begin
            if (!m[0]) begin
                mosi = d[i];
                wait_h();
                got[i] = miso;
                sclk = ~sclk;
                wait_h();
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = d[i];
                wait_h();
                got[i] = miso;
                sclk = ~sclk;
                wait_h();
            end
        end
    endtask

    initial begin
        logic [7:0] got, got2, last_rx;
        int r0, t0, f0;
        vecs[0] = '{2'd0, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
        vecs[1] = '{2'd1, 8'h3C, 8'h96, 8'h3C, 8'h96};
        vecs[2] = '{2'd2, 8'h3C, 8'h96, 8'h3C, 8'h96};
        vecs[3] = '{2'd3, 8'h3C, 8'h96, 8'h3C, 8'h96};
        vecs[4] = '{2'd0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'd0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_h();
        for (int v = 0; v < 5; v++) begin
            tx_data = vecs[v].tx_b;
            sb.push_back(vecs[v].exp_rx);
            r0 = rxv_cnt; t0 = txl_cnt; f0 = fe_cnt;
            cs_low(vecs[v].m);
            chk("busy_after_cs_fall", {31'd0, busy}, 32'd1);
            chk("tx_load_at_cs_fall", 32'(txl_cnt - t0), 32'd1);
            xfer_bits(vecs[v].m, vecs[v].mosi_b, 8, got);
            cs_high();
            chk("miso_bits", {24'd0, got}, {24'd0, vecs[v].exp_miso});
            chk("rx_valid_pulses", 32'(rxv_cnt - r0), 32'd1);
            chk("frame_err_none", 32'(fe_cnt - f0), 32'd0);
            chk("rx_data_final", {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
            chk("busy_after_cs_rise", {31'd0, busy}, 32'd0);
            chk("sb_drained", 32'(sb.size()), 32'd0);
        end
        last_rx = vecs[4].exp_rx;
        // Two bytes under one cs; the second tx byte is presented after the cs-fall load.
        tx_data = 8'hC3;
        sb.push_back(8'h12);
        sb.push_back(8'hF0);
        r0 = rxv_cnt; t0 = txl_cnt;
        cs_low(2'd0);
        chk("b2b_tx_load_fall", 32'(txl_cnt - t0), 32'd1);
        tx_data = 8'h5A;
        xfer_bits(2'd0, 8'h12, 8, got);
        chk("b2b_tx_load_wrap", 32'(txl_cnt - t0), 32'd2);
        xfer_bits(2'd0, 8'hF0, 8, got2);
        cs_high();
        chk("b2b_miso_byte1", {24'd0, got}, 32'hC3);
        chk("b2b_miso_byte2", {24'd0, got2}, 32'h5A);
        chk("b2b_rx_valid_pulses", 32'(rxv_cnt - r0), 32'd2);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);
        last_rx = 8'hF0;
        // Mode 3 partial frame of 5 bits.
        r0 = rxv_cnt; f0 = fe_cnt;
        tx_data = 8'h11;
        cs_low(2'd3);
        xfer_bits(2'd3, 8'hFF, 5, got);
        cs_high();
        chk("partial_frame_err", 32'(fe_cnt - f0), 32'd1);
        chk("partial_no_rx_valid", 32'(rxv_cnt - r0), 32'd0);
        chk("partial_rx_data_kept", {24'd0, rx_data}, {24'd0, last_rx});
        chk("partial_busy", {31'd0, busy}, 32'd0);
        sb.push_back(8'h81);
        r0 = rxv_cnt; f0 = fe_cnt;
        cs_low(2'd3);
        xfer_bits(2'd3, 8'h81, 8, got);
        cs_high();
        chk("after_partial_rx_valid", 32'(rxv_cnt - r0), 32'd1);
        chk("after_partial_rx_data", {24'd0, rx_data}, 32'h81);
        chk("after_partial_no_err", 32'(fe_cnt - f0), 32'd0);
        // Reset after 4 bits in mode 1.
        r0 = rxv_cnt; f0 = fe_cnt;
        tx_data = 8'hFF;
        cs_low(2'd1);
        xfer_bits(2'd1, 8'hF0, 4, got);
        rst = 1'b1;
        #1;
        chk("midrst_miso", {31'd0, miso}, 32'd0);
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_strobes", {29'd0, rx_valid, tx_load, frame_err}, 32'd0);
        cs = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_h();
        chk("midrst_no_strobes", 32'(rxv_cnt - r0) + 32'(fe_cnt - f0), 32'd0);
        sb.push_back(8'h7E);
        tx_data = 8'h24;
        r0 = rxv_cnt;
        cs_low(2'd1);
        xfer_bits(2'd1, 8'h7E, 8, got);
        cs_high();
        chk("post_rst_rx_data", {24'd0, rx_data}, 32'h7E);
        chk("post_rst_rx_valid", 32'(rxv_cnt - r0), 32'd1);
        chk("post_rst_miso", {24'd0, got}, 32'h24);
        // sclk toggling with cs high must be ignored.
        r0 = rxv_cnt; t0 = txl_cnt;
        mode = 2'd0;
        for (int e = 0; e < 8; e++) begin
            sclk = ~sclk;
            mosi = ~mosi;
            wait_h();
            chk("idle_miso", {31'd0, miso}, 32'd0);
        end
        wait_h();
        chk("idle_no_rx_valid", 32'(rxv_cnt - r0), 32'd0);
        chk("idle_no_tx_load", 32'(txl_cnt - t0), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
